// File: rtl/iir_pkg.sv
// Shared constants for the biquad cascade: coefficient word indices inside a
// section, the scale address and the sample guard length.
package iir_pkg;

  localparam int IIR_IDX_B0 = 0;
  localparam int IIR_IDX_B1 = 1;
  localparam int IIR_IDX_B2 = 2;
  localparam int IIR_IDX_A1 = 3;
  localparam int IIR_IDX_A2 = 4;

  // Scale sits directly after the last section's a2.
  function automatic int IIR_SCALE_ADDR(input int level);
    return level * (IIR_IDX_A2 + 1);
  endfunction

  // Cycles a sample occupies the cascade: one scale cycle plus one per section.
  function automatic int IIR_GUARD_LEN(input int level);
    return level + 1;
  endfunction

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

endpackage

// File: rtl/iir_coef_bank_if.sv
// Shadow-bank write and commit port of iir_coef_bank.
// Handshake: wr_en is the valid; a word is taken on an edge where
// wr_en && wr_rdy. wr_rdy never depends on wr_en in the same cycle.
interface iir_coef_bank_if #(
    parameter int AWIDTH = 6,
    parameter int CWIDTH = 24
);
    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [CWIDTH-1:0] wr_data;
    logic              commit;
    logic              wr_rdy;
    logic              commit_done;

    modport master (
        output wr_en, wr_addr, wr_data, commit,
        input  wr_rdy, commit_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        output wr_rdy, commit_done
    );
endinterface

// File: rtl/iir_sample_guard.sv
// Tracks whether a sample is still travelling through the cascade, marks the
// edges where coefficients may change, and flags samples that arrive too fast.
module iir_sample_guard
    import iir_pkg::*;
#(
    parameter int CASCADE_LEVEL = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic block_en,
    input  logic din_vld,
    input  logic ovr_clr,
    output logic safe,
    output logic overrun
);

    localparam int GUARD_LEN = IIR_GUARD_LEN(CASCADE_LEVEL);
    localparam int GW        = $clog2(GUARD_LEN + 1);
    localparam logic [GW-1:0] GLOAD = GW'(GUARD_LEN);

    logic [GW-1:0] gcnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gcnt <= '0;
        end else if (!block_en) begin
            gcnt <= '0;
        end else if (din_vld) begin
            gcnt <= GLOAD;
        end else if (gcnt != '0) begin
            gcnt <= gcnt - GW'(1);
        end
    end

    // A disabled cascade holds no sample, so every edge is safe regardless of gcnt.
    assign safe = !block_en || (!din_vld && (gcnt <= GW'(1)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun <= 1'b0;
        end else if (!block_en) begin
            overrun <= 1'b0;
        end else if (din_vld && (gcnt >= GW'(2))) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/iir_coef_bank.sv
// Double-buffered coefficient/scale store for the biquad cascade. The shadow
// bank is copied to the active bank only on edges where no sample is in flight.
module iir_coef_bank
    import iir_pkg::*;
#(
    parameter int CASCADE_LEVEL = 10,
    parameter int CWIDTH        = 24,
    parameter int AWIDTH        = 6
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              block_en,
    input  logic                              din_vld,
    input  logic                              ovr_clr,
    iir_coef_bank_if.slave                    bus,
    output logic                              overrun,
    output logic                              addr_err,
    output logic [CASCADE_LEVEL*CWIDTH*5-1:0] coefs,
    output logic [CWIDTH-1:0]                 scale,
    output commit_state_e                     dbg_state
);

    localparam int NWORDS = IIR_SCALE_ADDR(CASCADE_LEVEL) + 1;
    localparam int BANK_W = NWORDS * CWIDTH;
    localparam logic [AWIDTH-1:0] SCALE_ADDR = AWIDTH'(IIR_SCALE_ADDR(CASCADE_LEVEL));

    commit_state_e     state, state_nxt;
    logic              safe;
    logic              swap;
    logic              wr_rdy;
    logic              wr_take;
    logic              commit_done_q;
    logic [BANK_W-1:0] shadow, shadow_nxt;

    iir_sample_guard #(
        .CASCADE_LEVEL(CASCADE_LEVEL)
    ) u_guard (
        .clk     (clk),
        .rstn    (rstn),
        .block_en(block_en),
        .din_vld (din_vld),
        .ovr_clr (ovr_clr),
        .safe    (safe),
        .overrun (overrun)
    );

    assign wr_rdy          = (state == ST_IDLE);
    assign wr_take         = bus.wr_en && wr_rdy;
    assign bus.wr_rdy      = wr_rdy;
    assign bus.commit_done = commit_done_q;
    assign dbg_state       = state;

    // Shadow layout matches {scale, coefs}, so the swap is a single copy.
    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        assign shadow_nxt[i*CWIDTH +: CWIDTH] =
            (wr_take && (bus.wr_addr == AWIDTH'(i))) ? bus.wr_data
                                                      : shadow[i*CWIDTH +: CWIDTH];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow <= '0;
        end else begin
            shadow <= shadow_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_err <= 1'b0;
        end else if (wr_take && (bus.wr_addr > SCALE_ADDR)) begin
            addr_err <= 1'b1;
        end else if (ovr_clr) begin
            addr_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A commit arriving while one is pending merges into it.
    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.commit) state_nxt = ST_PENDING;
            end
            ST_PENDING: begin
                if (safe) begin
                    swap      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coefs         <= '0;
            scale         <= '0;
            commit_done_q <= 1'b0;
        end else begin
            commit_done_q <= swap;
            if (swap) begin
                {scale, coefs} <= shadow;
            end
        end
    end

endmodule

// File: doc/iir_coef_bank.md
# iir_coef_bank

Double-buffered coefficient and scale store that directly feeds the cascaded biquad engine (`coefs`, `scale` inputs). Software or a control FSM writes a shadow bank word by word, then requests a commit. The block swaps shadow into the active bank only at a clock edge where no sample is in flight in the cascade, so a sample is never filtered with mixed coefficient sets. It also flags input samples that arrive faster than the cascade can process them.

## Interface
- `CASCADE_LEVEL`, 10: number of biquad sections; must match the cascade.
- `CWIDTH`, 24: coefficient/scale word width.
- `AWIDTH`, 6: write address width; must satisfy 2^AWIDTH > CASCADE_LEVEL*5.
- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous active-low reset.
- `block_en`  in  1  same enable as the cascade; low = cascade idle.
- `din_vld`  in  1  sample strobe, tapped from the cascade input.
- `wr_en`  in  1  shadow write strobe; accepted only when `wr_rdy`=1.
- `wr_addr`  in  AWIDTH  word address: section s, index k gives addr = s*5+k (k: 0 b0, 1 b1, 2 b2, 3 a1, 4 a2); addr CASCADE_LEVEL*5 is scale.
- `wr_data`  in  CWIDTH  word to write.
- `commit`  in  1  one-cycle request to swap shadow into active.
- `ovr_clr`  in  1  clears `overrun`.
- `wr_rdy`  out  1  high when no commit is pending.
- `commit_done`  out  1  one-cycle pulse on the cycle after the swap edge.
- `overrun`  out  1  sticky sample-overrun flag.
- `addr_err`  out  1  sticky flag: write to an address > CASCADE_LEVEL*5; cleared by `ovr_clr`.
- `coefs`  out  CASCADE_LEVEL*CWIDTH*5  active bank. Section s occupies bits [(s+1)*5*CWIDTH-1 : s*5*CWIDTH], packed {a2,a1,b2,b1,b0} with b0 in the LSBs.
- `scale`  out  CWIDTH  active scale.

## Operation
- Reset values:
  - shadow, active, `coefs`, `scale`: 0.
  - `wr_rdy`: 1.
  - `commit_done`, `overrun`, `addr_err`: 0.
  - guard counter `gcnt`: 0; `pending`: 0.
- Guard counter:
  - `din_vld`=1 loads `gcnt` with CASCADE_LEVEL+1.
  - Otherwise `gcnt` decrements while nonzero.
  - `block_en`=0 forces `gcnt`=0.
- Safe edge: `din_vld`=0 and `gcnt`≤1. This guarantees `scale` is stable during the sample cycle and `coefs` are stable through all CASCADE_LEVEL section cycles that follow.
- Write: when `wr_en` && `wr_rdy` and the address is valid, shadow[addr] <= `wr_data`. Invalid address: no write, `addr_err`<=1. When `wr_rdy`=0, `wr_en` is ignored with no flag.
- Commit:
  - `commit` sets `pending`; `wr_rdy` = ~`pending`.
  - `wr_en` and `commit` in the same cycle: the write lands first and is included in the commit.
  - `commit` while already pending: merged, no effect.
- Swap: at a safe edge with `pending`=1, active <= shadow (whole bank plus scale), `pending`<=0, `commit_done`<=1 for one cycle. Shadow keeps its contents.
- Overrun: `din_vld`=1 with `gcnt`≥2 sets `overrun`. Set has priority over a simultaneous `ovr_clr`.
- `block_en`=0: `pending` is kept; the swap happens at the next edge because every edge is safe. `overrun` clears. Shadow and active banks are retained.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous).

## Timing
- `din_vld` at cycle t makes cycles t+1 .. t+CASCADE_LEVEL+1 unsafe. The earliest swap is the edge ending cycle t+CASCADE_LEVEL+1, with new values visible from t+CASCADE_LEVEL+2.
- When idle, `commit` at cycle c produces the swap at the edge ending c+1, new `coefs` in c+2, and `commit_done` in c+2.
- `coefs` and `scale` are direct register outputs with no combinational path from the inputs.
- The minimum legal sample spacing is CASCADE_LEVEL+1 cycles.

## Structure
- Shared package `iir_pkg`:
  - address constants `IIR_IDX_B0` .. `IIR_IDX_A2` (0..4).
  - `IIR_SCALE_ADDR(level)`.
  - the guard length CASCADE_LEVEL+1.
- One sub-module, `iir_sample_guard`: `gcnt`, safe-edge and overrun logic. It is reusable by other consumers of the cascade.
- Target size is roughly 200 lines of RTL.

## Test plan
All scenarios use CASCADE_LEVEL=10.
- Reset, then write all 51 words (addr i gets value i+1), then `commit` while idle. Expect the swap in 2 cycles and `coefs` section 0 = {5,4,3,2,1}.
- `din_vld` at t=100, `commit` at t=101. Expect the swap at the edge ending t=111 and `commit_done` high at t=112. `coefs` must be unchanged through t=111.
- `din_vld` at t=100 and again at t=105. Expect `overrun`=1 at t=106. A third `din_vld` at t=200 after `ovr_clr` leaves `overrun` at 0.
- Write addr 51 with 0xABCDEF. Expect `addr_err`=1 and shadow unchanged (verified by a commit).
- `commit` pending, then `wr_en` to addr 0. Expect the write ignored and `wr_rdy`=0 until `commit_done`.
- `block_en`=0 with a commit pending and `gcnt`=8. Expect the swap on the next edge.
